vdisk_arbiter: RTL and testbench

Arbitrates the single hps_io virtual-disk sector channel among NBDRIV floppy drives. Each drive issues a level-held read or write sector request with its own LBA. The block grants one drive at a time in round-robin order and drives that drive's `sd_rd`/`sd_wr` bit with the latched LBA. It tags sector-buffer traffic with the granted drive number and pulses a per-drive completion. It sits between the trs80 FDC and hps_io, replacing the shared-LBA / OR'd-ack wiring at the emu top level.

---
 rtl/vdisk_arbiter_if.sv | 30 +++
 rtl/vdisk_arbiter.sv | 132 +++++++++++++
 tb/tb_vdisk_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vdisk_arbiter_if.sv
// Virtual-disk sector channel bundle: per-drive FDC request side plus the hps_io sd_* side.
// The arbiter takes the slave view; the surrounding emu top (or a bench) takes the master view.
interface vdisk_arbiter_if #(
    parameter int NBDRIV = 4
);
    logic [NBDRIV-1:0]    req_rd;
    logic [NBDRIV-1:0]    req_wr;
    logic [NBDRIV*32-1:0] req_lba;
    logic [NBDRIV-1:0]    req_done;
    logic                 req_err;
    logic                 busy;
    logic [1:0]           grant;
    logic [31:0]          sd_lba;
    logic [NBDRIV-1:0]    sd_rd;
    logic [NBDRIV-1:0]    sd_wr;
    logic [NBDRIV-1:0]    sd_ack;
    logic                 sd_buff_wr;
    logic                 buff_wr;
    logic [1:0]           buff_drive;

    modport slave (
        input  req_rd, req_wr, req_lba, sd_ack, sd_buff_wr,
        output req_done, req_err, busy, grant, sd_lba, sd_rd, sd_wr, buff_wr, buff_drive
    );

    modport master (
        output req_rd, req_wr, req_lba, sd_ack, sd_buff_wr,
        input  req_done, req_err, busy, grant, sd_lba, sd_rd, sd_wr, buff_wr, buff_drive
    );
endinterface

// File: rtl/vdisk_arbiter.sv
// Round-robin arbiter sharing the hps_io virtual-disk sector channel among NBDRIV floppy drives.
// Define VDISK_TIMEOUT_EN to build the ack watchdog (TIMEOUT_CYC cycles) that aborts with req_err.
module vdisk_arbiter #(
    parameter int NBDRIV      = 4,
    parameter int TIMEOUT_CYC = 1 << 24
) (
    input  logic           clk_sys,
    input  logic           reset,
    vdisk_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    if (NBDRIV < 2 || NBDRIV > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("vdisk_arbiter: NBDRIV must be 2..4 and TIMEOUT_CYC at least 2");
    end

    state_t            state, state_nxt;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic [1:0]        pick;
    logic              pick_vld;
    logic              op_wr;
    logic              strobe, strobe_nxt;
    logic              timeout;
    logic              ack_g;
    logic              active;
    logic [31:0]       lba;
    logic [NBDRIV-1:0] pend;
    logic [NBDRIV-1:0] grant_oh;

    assign pend     = bus.req_rd | bus.req_wr;
    assign ack_g    = bus.sd_ack[grant];
    assign grant_oh = NBDRIV'(1) << grant;
    assign active   = (state == REQ) || (state == XFER);

    // First pending drive at or after ptr, wrapping at NBDRIV.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pick     = ptr;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = NBDRIV - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NBDRIV)) sum = sum - 3'(NBDRIV);
            idx = sum[1:0];
            if (pend[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = REQ;
            REQ:     if (timeout) state_nxt = DONE; else if (ack_g) state_nxt = XFER;
            XFER:    if (timeout || !ack_g) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe is registered one cycle behind REQ entry and drops on the edge that samples ack.
    always_comb begin
        strobe_nxt = (state == REQ) && !ack_g && !timeout;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            grant  <= '0;
            lba    <= '0;
            op_wr  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            strobe <= strobe_nxt;
            if (state == IDLE && pick_vld) begin
                grant <= pick;
                lba   <= bus.req_lba[{pick, 5'd0} +: 32];
                op_wr <= bus.req_wr[pick];
            end
            if (state == DONE) ptr <= (grant == 2'(NBDRIV - 1)) ? 2'd0 : grant + 2'd1;
        end
    end

`ifdef VDISK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt;
    logic          aborted;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            aborted <= 1'b0;
        end else begin
            if (state == IDLE) begin
                tmo_cnt <= '0;
                aborted <= 1'b0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (timeout) aborted <= 1'b1;
            end
        end
    end

    assign timeout     = active && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign bus.req_err = (state == DONE) && aborted;
`else
    assign timeout     = 1'b0;
    assign bus.req_err = 1'b0;
`endif

    assign bus.busy       = (state != IDLE);
    assign bus.grant      = grant;
    assign bus.sd_lba     = lba;
    assign bus.sd_rd      = {NBDRIV{strobe && !op_wr}} & grant_oh;
    assign bus.sd_wr      = {NBDRIV{strobe && op_wr}} & grant_oh;
    assign bus.req_done   = {NBDRIV{state == DONE}} & grant_oh;
    assign bus.buff_wr    = bus.sd_buff_wr && ack_g && active;
    assign bus.buff_drive = grant;
endmodule

// File: tb/tb_vdisk_arbiter.sv
// Bench for vdisk_arbiter: table of single-request transactions, round-robin run, foreign ack,
// buffer gating and asynchronous reset; expected grants/strobes go through a scoreboard queue.
module tb_vdisk_arbiter;
    localparam int NBDRIV = 4;

    typedef struct packed {
        logic [1:0]  grant;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] lba;
    } exp_t;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] base;
        int          ack_delay;
        int          ack_len;
        exp_t        exp;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    vdisk_arbiter_if #(.NBDRIV(NBDRIV)) bus ();

    vdisk_arbiter #(.NBDRIV(NBDRIV), .TIMEOUT_CYC(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_lba(input logic [31:0] base);
        for (int i = 0; i < NBDRIV; i++) bus.req_lba[32*i +: 32] = base + 32'(i);
    endtask

    // Wait (bounded) for a strobe, pop the expected grant and compare the strobe-cycle outputs.
    task automatic take_grant(input string tag, output exp_t e);
        logic seen;
        int   c;
        seen = 1'b0;
        c    = 0;
        while (!seen && c < 20) begin
            tick();
            c++;
            if ((bus.sd_rd | bus.sd_wr) != '0) seen = 1'b1;
        end
        check({tag, " strobe_seen"}, 64'(seen), 64'd1);
        check({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        check({tag, " grant"}, 64'(bus.grant), 64'(e.grant));
        check({tag, " sd_rd"}, 64'(bus.sd_rd), 64'(e.rd));
        check({tag, " sd_wr"}, 64'(bus.sd_wr), 64'(e.wr));
        check({tag, " sd_lba"}, 64'(bus.sd_lba), 64'(e.lba));
        check({tag, " buff_drive"}, 64'(bus.buff_drive), 64'(e.grant));
    endtask

    task automatic run_xact(input string tag, input int ack_delay, input int ack_len,
                            input logic drop_req);
        exp_t e;
        int   g;
        take_grant(tag, e);
        g = int'(e.grant);
        repeat (ack_delay) tick();
        check({tag, " strobe_hold"}, 64'(bus.sd_rd | bus.sd_wr), 64'(e.rd | e.wr));
        bus.sd_ack[g] = 1'b1;
        tick();
        check({tag, " strobe_drop"}, 64'(bus.sd_rd | bus.sd_wr), 64'd0);
        check({tag, " busy_xfer"}, 64'(bus.busy), 64'd1);
        repeat (ack_len - 1) tick();
        bus.sd_ack[g] = 1'b0;
        tick();
        check({tag, " req_done"}, 64'(bus.req_done), 64'(4'b0001 << g));
        check({tag, " req_err"}, 64'(bus.req_err), 64'd0);
        check({tag, " grant_at_done"}, 64'(bus.grant), 64'(e.grant));
        if (drop_req) begin
            bus.req_rd = '0;
            bus.req_wr = '0;
        end
        tick();
        check({tag, " done_one_cycle"}, 64'(bus.req_done), 64'd0);
        if (drop_req) check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "tb_vdisk_arbiter: global timeout");
    end

    initial begin
        exp_t e;
        // rd, wr, lba base, ack delay, ack len, {grant, sd_rd, sd_wr, sd_lba}; ptr carries over.
        vecs[0] = '{4'b0010, 4'b0000, 32'h0000_0011, 3, 5, '{2'd1, 4'b0010, 4'b0000, 32'h0000_0012}};
        vecs[1] = '{4'b0100, 4'b0100, 32'hABCD_0000, 0, 1, '{2'd2, 4'b0000, 4'b0100, 32'hABCD_0002}};
        vecs[2] = '{4'b0011, 4'b0000, 32'h0000_0300, 1, 2, '{2'd0, 4'b0001, 4'b0000, 32'h0000_0300}};
        vecs[3] = '{4'b0000, 4'b1000, 32'hFFFF_FFFC, 2, 3, '{2'd3, 4'b0000, 4'b1000, 32'hFFFF_FFFF}};
        vecs[4] = '{4'b1010, 4'b0000, 32'h0000_0040, 1, 1, '{2'd1, 4'b0010, 4'b0000, 32'h0000_0041}};
        vecs[5] = '{4'b0001, 4'b1000, 32'h0000_7000, 0, 2, '{2'd3, 4'b0000, 4'b1000, 32'h0000_7003}};

        bus.req_rd     = '0;
        bus.req_wr     = '0;
        bus.req_lba    = '0;
        bus.sd_ack     = 4'b1111;
        bus.sd_buff_wr = 1'b1;
        repeat (3) tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset grant", 64'(bus.grant), 64'd0);
        check("reset sd_lba", 64'(bus.sd_lba), 64'd0);
        check("reset strobes", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        check("reset done_err", 64'({bus.req_done, bus.req_err}), 64'd0);
        check("reset buff_wr", 64'(bus.buff_wr), 64'd0);
        bus.sd_ack     = '0;
        bus.sd_buff_wr = 1'b0;
        reset          = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            set_lba(vecs[i].base);
            bus.req_rd = vecs[i].rd;
            bus.req_wr = vecs[i].wr;
            sb.push_back(vecs[i].exp);
            run_xact($sformatf("vec%0d", i), vecs[i].ack_delay, vecs[i].ack_len, 1'b1);
        end

        // Round-robin with all drives holding a read; ptr is 0 here.
        set_lba(32'h0000_0500);
        bus.req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e.grant = 2'(k % 4);
            e.rd    = 4'b0001 << (k % 4);
            e.wr    = 4'b0000;
            e.lba   = 32'h0000_0500 + 32'(k % 4);
            sb.push_back(e);
        end
        for (int k = 0; k < 5; k++) run_xact($sformatf("rr%0d", k), 1, 2, k == 4);

        // Foreign ack and buffer gating on drive 0 (ptr is 1, so the search wraps to 0).
        set_lba(32'h0000_0100);
        bus.req_rd = 4'b0001;
        sb.push_back('{2'd0, 4'b0001, 4'b0000, 32'h0000_0100});
        take_grant("fack", e);
        bus.sd_ack[3]  = 1'b1;
        bus.sd_buff_wr = 1'b1;
        #1;
        check("fack buff_wr_foreign", 64'(bus.buff_wr), 64'd0);
        tick();
        check("fack strobe_kept", 64'(bus.sd_rd), 64'(4'b0001));
        bus.sd_ack[3] = 1'b0;
        tick();
        check("fack strobe_kept2", 64'(bus.sd_rd), 64'(4'b0001));
        bus.sd_ack[0] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.sd_buff_wr = i[0];
            #1;
            check($sformatf("fack buff_wr%0d", i), 64'(bus.buff_wr), 64'(i[0]));
            check($sformatf("fack buff_drive%0d", i), 64'(bus.buff_drive), 64'd0);
            tick();
        end
        bus.sd_buff_wr = 1'b1;
        bus.sd_ack[0]  = 1'b0;
        #1;
        check("fack buff_wr_noack", 64'(bus.buff_wr), 64'd0);
        bus.sd_buff_wr = 1'b0;
        tick();
        check("fack req_done", 64'(bus.req_done), 64'(4'b0001));
        bus.req_rd = '0;
        tick();

        // Asynchronous reset in XFER on drive 2; afterwards the search must restart at 0.
        set_lba(32'h0000_0200);
        bus.req_rd = 4'b0100;
        sb.push_back('{2'd2, 4'b0100, 4'b0000, 32'h0000_0202});
        take_grant("rst", e);
        bus.sd_ack[2] = 1'b1;
        tick();
        tick();
        check("rst in_xfer", 64'(bus.busy), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rst strobes", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst req_done", 64'(bus.req_done), 64'd0);
        check("rst grant", 64'(bus.grant), 64'd0);
        bus.sd_ack = '0;
        tick();
        reset = 1'b0;
        set_lba(32'h0000_0900);
        bus.req_rd = 4'b1111;
        sb.push_back('{2'd0, 4'b0001, 4'b0000, 32'h0000_0900});
        run_xact("post_rst", 1, 1, 1'b1);

`ifdef VDISK_TIMEOUT_EN
        begin
            int n_req;
            n_req = 0;
            set_lba(32'h0000_0A00);
            bus.req_rd = 4'b0010;
            tick();
            while (bus.busy && bus.req_done == '0 && n_req < 40) begin
                n_req++;
                tick();
            end
            check("tmo req_cycles", 64'(n_req), 64'd16);
            check("tmo strobe_drop", 64'(bus.sd_rd), 64'd0);
            check("tmo req_done", 64'(bus.req_done), 64'(4'b0010));
            check("tmo req_err", 64'(bus.req_err), 64'd1);
            bus.req_rd = '0;
            tick();
            check("tmo err_one_cycle", 64'(bus.req_err), 64'd0);
        end
`endif

        check("sb drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
